// File: rtl/approx_add_err_monitor.sv
`default_nettype none
// ============================================================================
// Module  : approx_add_err_monitor
// Brief   : Exact-vs-approximate adder error statistics over fixed-length runs.
//           Optional signed bias accumulator is built when ERR_BIAS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module approx_add_err_monitor #(
    parameter int WIDTH   = 8,
    parameter int SAMPLES = 256,
    parameter int CNT_W   = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 op_a,
    input  logic [WIDTH-1:0]                 op_b,
    input  logic                             op_cin,
    input  logic [WIDTH:0]                   approx_res,
    output logic                             busy,
    output logic                             done,
    output logic [CNT_W-1:0]                 total_cnt,
    output logic [CNT_W-1:0]                 err_cnt,
    output logic [CNT_W+WIDTH:0]             ed_sum,
    output logic [WIDTH:0]                   max_ed,
    output logic signed [CNT_W+WIDTH+1:0]    bias_sum
);

    localparam int c_RW  = WIDTH + 1;
    localparam int c_ESW = CNT_W + WIDTH + 1;
    localparam int c_BSW = CNT_W + WIDTH + 2;
    localparam int c_AW  = $clog2(SAMPLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_AW-1:0]    r_acc_cnt;
    logic               w_accept;
    logic               w_last;
    logic               w_start_run;

    logic               r_s1_vld;
    logic [c_RW-1:0]    r_s1_exact;
    logic [c_RW-1:0]    r_s1_approx;
    logic               r_s2_vld;
    logic [c_RW-1:0]    r_s2_ed;
    logic [c_RW-1:0]    w_exact;
    logic [c_RW-1:0]    w_ed;

    logic [CNT_W-1:0]   r_total;
    logic [CNT_W-1:0]   r_err;
    logic [c_ESW-1:0]   r_ed_sum;
    logic [c_RW-1:0]    r_max_ed;
    logic [c_ESW:0]     w_ed_sum_wide;

    assign w_accept    = in_valid && (r_state == S_RUN);
    assign w_last      = w_accept && (r_acc_cnt == c_AW'(SAMPLES - 1));
    assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_acc_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_run)
                r_acc_cnt <= '0;
            else if (w_accept)
                r_acc_cnt <= r_acc_cnt + c_AW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_last)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!r_s1_vld && !r_s2_vld)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start)
                    w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Exact reference sum is WIDTH+1 bits wide, so it can never overflow.
    assign w_exact = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
    assign w_ed    = (r_s1_exact >= r_s1_approx) ? (r_s1_exact - r_s1_approx)
                                                 : (r_s1_approx - r_s1_exact);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld    <= 1'b0;
            r_s1_exact  <= '0;
            r_s1_approx <= '0;
            r_s2_vld    <= 1'b0;
            r_s2_ed     <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_exact  <= w_exact;
                r_s1_approx <= approx_res;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld)
                r_s2_ed <= w_ed;
        end
    end

    assign w_ed_sum_wide = {1'b0, r_ed_sum} + (c_ESW + 1)'(r_s2_ed);

    always_ff @(posedge clk) begin
        if (rst || w_start_run) begin
            r_total  <= '0;
            r_err    <= '0;
            r_ed_sum <= '0;
            r_max_ed <= '0;
        end else if (r_s2_vld) begin
            if (r_total != '1)
                r_total <= r_total + CNT_W'(1);
            if ((r_s2_ed != '0) && (r_err != '1))
                r_err <= r_err + CNT_W'(1);
            r_ed_sum <= w_ed_sum_wide[c_ESW] ? '1 : w_ed_sum_wide[c_ESW-1:0];
            if (r_s2_ed > r_max_ed)
                r_max_ed <= r_s2_ed;
        end
    end

    assign total_cnt = r_total;
    assign err_cnt   = r_err;
    assign ed_sum    = r_ed_sum;
    assign max_ed    = r_max_ed;

`ifdef ERR_BIAS_EN
    localparam logic [c_BSW-1:0] c_BIAS_MAX = {1'b0, {(c_BSW-1){1'b1}}};
    localparam logic [c_BSW-1:0] c_BIAS_MIN = {1'b1, {(c_BSW-1){1'b0}}};

    logic [c_RW:0]    r_s2_diff;
    logic [c_BSW-1:0] r_bias_sum;
    logic [c_BSW:0]   w_bias_wide;

    // One guard bit above the accumulator; disagreeing top bits mean overflow.
    assign w_bias_wide = {r_bias_sum[c_BSW-1], r_bias_sum}
                       + {{(c_BSW-c_RW){r_s2_diff[c_RW]}}, r_s2_diff};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_diff  <= '0;
            r_bias_sum <= '0;
        end else begin
            if (r_s1_vld)
                r_s2_diff <= {1'b0, r_s1_approx} - {1'b0, r_s1_exact};
            if (w_start_run)
                r_bias_sum <= '0;
            else if (r_s2_vld) begin
                if (w_bias_wide[c_BSW] != w_bias_wide[c_BSW-1])
                    r_bias_sum <= w_bias_wide[c_BSW] ? c_BIAS_MIN : c_BIAS_MAX;
                else
                    r_bias_sum <= w_bias_wide[c_BSW-1:0];
            end
        end
    end

    assign bias_sum = $signed(r_bias_sum);
`else
    assign bias_sum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_approx_add_err_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_approx_add_err_monitor
// Brief   : Scoreboard bench for approx_add_err_monitor (WIDTH=8, SAMPLES=16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_approx_add_err_monitor;

    localparam int W = 8;
    localparam int S = 16;
    localparam int C = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   in_valid;
    logic                   in_ready;
    logic [W-1:0]           op_a;
    logic [W-1:0]           op_b;
    logic                   op_cin;
    logic [W:0]             approx_res;
    logic                   busy;
    logic                   done;
    logic [C-1:0]           total_cnt;
    logic [C-1:0]           err_cnt;
    logic [C+W:0]           ed_sum;
    logic [W:0]             max_ed;
    logic signed [C+W+1:0]  bias_sum;

    typedef struct packed {
        logic [W:0] ex;
        logic [W:0] ap;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    int    n_acc    = 0;
    int    last_acc = 0;

    approx_add_err_monitor #(.WIDTH(W), .SAMPLES(S), .CNT_W(C)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_cin     (op_cin),
        .approx_res (approx_res),
        .busy       (busy),
        .done       (done),
        .total_cnt  (total_cnt),
        .err_cnt    (err_cnt),
        .ed_sum     (ed_sum),
        .max_ed     (max_ed),
        .bias_sum   (bias_sum)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] exact_of(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard push: one expected beat per handshake seen on the clock edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) begin
            n_acc    <= n_acc + 1;
            last_acc <= cyc + 1;
            exp_q.push_back({exact_of(op_a, op_b, op_cin), approx_res});
        end
    end

    task automatic pulse_start(input string nm);
        exp_q.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk({nm, "_start_busy"},  64'(busy),      64'd1);
        chk({nm, "_start_done"},  64'(done),      64'd0);
        chk({nm, "_start_total"}, 64'(total_cnt), 64'd0);
        chk({nm, "_start_edsum"}, 64'(ed_sum),    64'd0);
    endtask

    // md: 0 exact, 1 exact+1, 2 random approx, 3 exact with lsb cleared
    task automatic drive_beats(input string nm, input int md, input int pct, input int cnt,
                               input int mid_start);
        int base;
        int guard;
        base  = n_acc;
        guard = 0;
        while ((n_acc - base < cnt) && (guard < 1000)) begin
            logic [W:0] ex;
            op_a       = (md == 1) ? W'($urandom_range(200)) : W'($urandom);
            op_b       = W'($urandom);
            op_cin     = 1'($urandom);
            ex         = exact_of(op_a, op_b, op_cin);
            case (md)
                0:       approx_res = ex;
                1:       approx_res = ex + 1'b1;
                2:       approx_res = (W+1)'($urandom);
                default: approx_res = {ex[W:1], 1'b0};
            endcase
            in_valid = ($urandom_range(99) < pct);
            start    = (guard == mid_start);
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b0;
        chk({nm, "_accepted"}, 64'(n_acc - base), 64'(cnt));
    endtask

    task automatic finish_run(input string nm);
        int    guard;
        int    rdy_bad;
        longint t, e, es, mx, bs, ed, exp_bias;
        beat_t bt;
        guard   = 0;
        rdy_bad = 0;
        in_valid = 1'b1;
        @(negedge clk);
        while (!done && guard < 20) begin
            if (in_ready) rdy_bad++;
            @(negedge clk);
            guard++;
        end
        chk({nm, "_done_latency"}, 64'(cyc - last_acc), 64'd3);
        chk({nm, "_ready_in_drain"}, 64'(rdy_bad), 64'd0);
        t = 0; e = 0; es = 0; mx = 0; bs = 0;
        chk({nm, "_queue_depth"}, 64'(exp_q.size()), 64'(S));
        while (exp_q.size() > 0) begin
            bt = exp_q.pop_front();
            ed = (bt.ex > bt.ap) ? longint'(bt.ex) - longint'(bt.ap)
                                 : longint'(bt.ap) - longint'(bt.ex);
            t++;
            if (ed != 0) e++;
            es += ed;
            if (ed > mx) mx = ed;
            bs += longint'(bt.ap) - longint'(bt.ex);
        end
`ifdef ERR_BIAS_EN
        exp_bias = bs;
`else
        exp_bias = 0;
`endif
        chk({nm, "_total"},  64'(total_cnt), 64'(t));
        chk({nm, "_err"},    64'(err_cnt),   64'(e));
        chk({nm, "_ed_sum"}, 64'(ed_sum),    64'(es));
        chk({nm, "_max_ed"}, 64'(max_ed),    64'(mx));
        chk({nm, "_bias"},   64'(bias_sum),  64'(exp_bias));
        chk({nm, "_busy"},   64'(busy),      64'd0);
        repeat (3) @(negedge clk);
        chk({nm, "_hold_total"}, 64'(total_cnt), 64'(t));
        chk({nm, "_hold_done"},  64'(done),      64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        op_a = '0; op_b = '0; op_cin = 1'b0; approx_res = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy",   64'(busy),      64'd0);
        chk("reset_done",   64'(done),      64'd0);
        chk("reset_ready",  64'(in_ready),  64'd0);
        chk("reset_total",  64'(total_cnt), 64'd0);
        chk("reset_max_ed", 64'(max_ed),    64'd0);
        chk("reset_bias",   64'(bias_sum),  64'd0);

        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ignores_valid", 64'(total_cnt), 64'd0);
        in_valid = 1'b0;

        pulse_start("exact");
        drive_beats("exact", 0, 100, S, -1);
        finish_run("exact");
        chk("exact_err_const", 64'(err_cnt), 64'd0);

        pulse_start("plus1");
        drive_beats("plus1", 1, 100, S, -1);
        finish_run("plus1");
        chk("plus1_ed_sum_const", 64'(ed_sum), 64'(S));
        chk("plus1_max_ed_const", 64'(max_ed), 64'd1);

        pulse_start("gaps");
        drive_beats("gaps", 2, 40, S, -1);
        finish_run("gaps");

        pulse_start("midstart");
        drive_beats("midstart", 3, 70, S, 5);
        finish_run("midstart");

        pulse_start("rstrun");
        drive_beats("rstrun", 2, 100, 5, -1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy",   64'(busy),      64'd0);
        chk("midrst_done",   64'(done),      64'd0);
        chk("midrst_total",  64'(total_cnt), 64'd0);
        chk("midrst_err",    64'(err_cnt),   64'd0);
        chk("midrst_ed_sum", 64'(ed_sum),    64'd0);
        chk("midrst_max_ed", 64'(max_ed),    64'd0);
        repeat (3) @(negedge clk);
        chk("midrst_flushed", 64'(total_cnt), 64'd0);
        chk("midrst_ready",   64'(in_ready),  64'd0);
        in_valid = 1'b0;

        pulse_start("after_rst");
        drive_beats("after_rst", 2, 100, S, -1);
        finish_run("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
